// File: rtl/sdram_wire_responder_if.sv
// Command, address and byte-mask side of the sdram_wire bus.
// dq is bidirectional, so it stays a plain inout port on the responder.
interface sdram_wire_responder_if;
  logic [12:0] sdram_wire_addr;
  logic [1:0]  sdram_wire_ba;
  logic        sdram_wire_cas_n;
  logic        sdram_wire_ras_n;
  logic        sdram_wire_we_n;
  logic        sdram_wire_cs_n;
  logic        sdram_wire_cke;
  logic [1:0]  sdram_wire_dqm;

  modport master (
    output sdram_wire_addr, sdram_wire_ba, sdram_wire_cas_n, sdram_wire_ras_n,
           sdram_wire_we_n, sdram_wire_cs_n, sdram_wire_cke, sdram_wire_dqm
  );

  modport slave (
    input  sdram_wire_addr, sdram_wire_ba, sdram_wire_cas_n, sdram_wire_ras_n,
           sdram_wire_we_n, sdram_wire_cs_n, sdram_wire_cke, sdram_wire_dqm
  );
endinterface

// File: rtl/sdram_wire_responder.sv
// Single-rank x16 SDR SDRAM device model: per-bank open rows, CL2/CL3 read pipeline, status outputs.
// Define SDRAM_RESP_ERRCHK_EN to enable protocol-violation detection on err/err_count.
module sdram_wire_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  sdram_wire_responder_if.slave sdram_wire,
  inout  wire  [15:0]           sdram_wire_dq,
  output logic                  mode_valid,
  output logic                  err,
  output logic [7:0]            err_count,
  output logic [15:0]           refresh_count
);

  localparam int ADDR_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  logic [12:0]          w_addr;
  logic [1:0]           w_ba;
  logic [1:0]           w_dqm;
  logic                 w_cmdEn;
  cmd_e                 w_cmd;
  logic                 w_isAct;
  logic                 w_isRead;
  logic                 w_isWrite;
  logic                 w_isPre;
  logic                 w_isRef;
  logic                 w_isLmr;
  logic                 w_modeLegal;
  logic                 w_unused;
  logic [ADDR_BITS-1:0] w_memAddr;

  bank_state_e          r_bankState     [4];
  bank_state_e          w_bankStateNext [4];
  logic [ROW_BITS-1:0]  r_bankRow       [4];
  logic [ROW_BITS-1:0]  w_bankRowNext   [4];

  logic                 r_modeValid;
  logic                 r_clIs3;
  logic [15:0]          r_refreshCount;

  logic [15:0]          r_mem [DEPTH];

  logic [1:0]           r_pipeValid;
  logic [1:0]           r_pipeMask [2];
  logic [15:0]          r_pipeData [2];
  logic                 r_outValid;
  logic [1:0]           r_outMask;
  logic [15:0]          r_outData;
  logic                 w_readPending;
  logic                 w_dropBeats;
  logic                 w_driveLo;
  logic                 w_driveHi;

  assign w_addr   = sdram_wire.sdram_wire_addr;
  assign w_ba     = sdram_wire.sdram_wire_ba;
  assign w_dqm    = sdram_wire.sdram_wire_dqm;
  assign w_cmdEn  = sdram_wire.sdram_wire_cke & ~sdram_wire.sdram_wire_cs_n;
  assign w_cmd    = cmd_e'({sdram_wire.sdram_wire_ras_n,
                            sdram_wire.sdram_wire_cas_n,
                            sdram_wire.sdram_wire_we_n});
  assign w_unused = ^w_addr;

  assign w_isAct   = w_cmdEn && (w_cmd == CMD_ACT);
  assign w_isRead  = w_cmdEn && (w_cmd == CMD_RD);
  assign w_isWrite = w_cmdEn && (w_cmd == CMD_WR);
  assign w_isPre   = w_cmdEn && (w_cmd == CMD_PRE);
  assign w_isRef   = w_cmdEn && (w_cmd == CMD_REF);
  assign w_isLmr   = w_cmdEn && (w_cmd == CMD_LMR);

  assign w_modeLegal = ((w_addr[6:4] == 3'd2) || (w_addr[6:4] == 3'd3)) && (w_addr[2:0] == 3'b000);

  // Accesses to an idle bank still land on whatever row that bank last latched.
  assign w_memAddr = {w_ba, r_bankRow[w_ba], w_addr[COL_BITS-1:0]};

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int b = 0; b < 4; b++) begin
        r_bankState[b] <= BANK_IDLE;
        r_bankRow[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        r_bankState[b] <= w_bankStateNext[b];
        r_bankRow[b]   <= w_bankRowNext[b];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_bankStateNext[b] = r_bankState[b];
      w_bankRowNext[b]   = r_bankRow[b];
    end
    if (w_isAct) begin
      w_bankStateNext[w_ba] = BANK_ACTIVE;
      w_bankRowNext[w_ba]   = w_addr[ROW_BITS-1:0];
    end
    if (w_isPre) begin
      if (w_addr[10]) begin
        for (int b = 0; b < 4; b++) begin
          w_bankStateNext[b] = BANK_IDLE;
        end
      end else begin
        w_bankStateNext[w_ba] = BANK_IDLE;
      end
    end
    if ((w_isRead || w_isWrite) && w_addr[10]) begin
      w_bankStateNext[w_ba] = BANK_IDLE;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_modeValid    <= 1'b0;
      r_clIs3        <= 1'b1;
      r_refreshCount <= 16'd0;
    end else begin
      if (w_isLmr && w_modeLegal) begin
        r_modeValid <= 1'b1;
        r_clIs3     <= (w_addr[6:4] == 3'd3);
      end
      if (w_isRef) begin
        r_refreshCount <= r_refreshCount + 16'd1;
      end
    end
  end

  assign mode_valid    = r_modeValid;
  assign refresh_count = r_refreshCount;

  // A beat still ahead of the output stage for the current CL counts as pending.
  assign w_readPending = r_pipeValid[0] | (r_clIs3 & r_pipeValid[1]);
  assign w_dropBeats   = w_isWrite & w_readPending;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_pipeValid   <= 2'b00;
      r_pipeMask[0] <= 2'b00;
      r_pipeMask[1] <= 2'b00;
      r_outValid    <= 1'b0;
      r_outMask     <= 2'b00;
    end else begin
      r_pipeValid[0] <= w_isRead;
      r_pipeMask[0]  <= w_dqm;
      r_pipeValid[1] <= r_pipeValid[0] & ~w_dropBeats;
      r_pipeMask[1]  <= r_pipeMask[0];
      if (w_dropBeats) begin
        r_outValid <= 1'b0;
      end else if (r_clIs3) begin
        r_outValid <= r_pipeValid[1];
        r_outMask  <= r_pipeMask[1];
      end else begin
        r_outValid <= r_pipeValid[0];
        r_outMask  <= r_pipeMask[0];
      end
    end
  end

  // Array and data path carry no reset; validity is tracked by the pipeline control above.
  always_ff @(posedge clk_clk) begin
    if (w_isWrite) begin
      if (!w_dqm[0]) r_mem[w_memAddr][7:0]  <= sdram_wire_dq[7:0];
      if (!w_dqm[1]) r_mem[w_memAddr][15:8] <= sdram_wire_dq[15:8];
    end
    r_pipeData[0] <= r_mem[w_memAddr];
    r_pipeData[1] <= r_pipeData[0];
    r_outData     <= r_clIs3 ? r_pipeData[1] : r_pipeData[0];
  end

  assign w_driveLo = r_outValid & ~r_outMask[0];
  assign w_driveHi = r_outValid & ~r_outMask[1];

  assign sdram_wire_dq = {w_driveHi ? r_outData[15:8] : 8'hzz,
                          w_driveLo ? r_outData[7:0]  : 8'hzz};

`ifdef SDRAM_RESP_ERRCHK_EN
  logic       w_anyActive;
  logic       w_violation;
  logic       r_err;
  logic [7:0] r_errCount;

  assign w_anyActive = (r_bankState[0] == BANK_ACTIVE) || (r_bankState[1] == BANK_ACTIVE) ||
                       (r_bankState[2] == BANK_ACTIVE) || (r_bankState[3] == BANK_ACTIVE);

  // Several violations on one edge still collapse into a single pulse.
  always_comb begin
    w_violation = 1'b0;
    if ((w_isRead || w_isWrite) && ((r_bankState[w_ba] == BANK_IDLE) || !r_modeValid))
      w_violation = 1'b1;
    if (w_isAct && (r_bankState[w_ba] == BANK_ACTIVE))
      w_violation = 1'b1;
    if ((w_isRef || w_isLmr) && w_anyActive)
      w_violation = 1'b1;
    if (w_isLmr && !w_modeLegal)
      w_violation = 1'b1;
    if (w_dropBeats)
      w_violation = 1'b1;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_err      <= 1'b0;
      r_errCount <= 8'd0;
    end else begin
      r_err <= w_violation;
      if (w_violation && (r_errCount != 8'hFF)) begin
        r_errCount <= r_errCount + 8'd1;
      end
    end
  end

  assign err       = r_err;
  assign err_count = r_errCount;
`else
  assign err       = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sdram_wire_responder.sv
// Directed self-checking bench for sdram_wire_responder; expectations follow SDRAM_RESP_ERRCHK_EN.
module tb_sdram_wire_responder;

  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_NOP = 3'b111;

`ifdef SDRAM_RESP_ERRCHK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        tbDqOe;
  logic [15:0] tbDqOut;
  wire  [15:0] dq;
  logic        modeValid;
  logic        err;
  logic [7:0]  errCount;
  logic [15:0] refreshCount;
  int          checkCount  = 0;
  int          errorCount  = 0;

  always #5 clock = ~clock;

  sdram_wire_responder_if busIf();

  assign dq = tbDqOe ? tbDqOut : 16'hzzzz;

  wire dqIsZ     = (dq === 16'hzzzz);
  wire dqHiZLo34 = (dq === 16'hzz34);

  sdram_wire_responder dut (
    .clk_clk       (clock),
    .reset_reset   (reset),
    .sdram_wire    (busIf),
    .sdram_wire_dq (dq),
    .mode_valid    (modeValid),
    .err           (err),
    .err_count     (errCount),
    .refresh_count (refreshCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one command for exactly one rising edge, then returns just after the next falling edge.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                               input logic [1:0] dqm, input logic drive, input logic [15:0] data);
    busIf.sdram_wire_cs_n = 1'b0;
    {busIf.sdram_wire_ras_n, busIf.sdram_wire_cas_n, busIf.sdram_wire_we_n} = cmd;
    busIf.sdram_wire_ba   = ba;
    busIf.sdram_wire_addr = addr;
    busIf.sdram_wire_dqm  = dqm;
    tbDqOe  = drive;
    tbDqOut = data;
    @(negedge clock);
    {busIf.sdram_wire_ras_n, busIf.sdram_wire_cas_n, busIf.sdram_wire_we_n} = CMD_NOP;
    busIf.sdram_wire_dqm = 2'b00;
    tbDqOe = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    tbDqOe  = 1'b0;
    tbDqOut = 16'h0000;
    busIf.sdram_wire_cke  = 1'b1;
    busIf.sdram_wire_cs_n = 1'b1;
    {busIf.sdram_wire_ras_n, busIf.sdram_wire_cas_n, busIf.sdram_wire_we_n} = CMD_NOP;
    busIf.sdram_wire_ba   = 2'd0;
    busIf.sdram_wire_addr = 13'd0;
    busIf.sdram_wire_dqm  = 2'b00;
    idle(3);
    checkOutput("rst_mode_valid", 32'(modeValid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_count", 32'(errCount), 32'd0);
    checkOutput("rst_refresh", 32'(refreshCount), 32'd0);
    checkOutput("rst_dq_z", 32'(dqIsZ), 32'd1);
    reset = 1'b0;
    idle(1);

    $display("[TB] load mode CL3");
    applyStimulus(CMD_LMR, 2'd0, 13'h030, 2'b00, 1'b0, 16'h0);
    checkOutput("lmr_mode_valid", 32'(modeValid), 32'd1);
    checkOutput("lmr_err", 32'(err), 32'd0);

    $display("[TB] write/read CL3 timing");
    applyStimulus(CMD_ACT, 2'd1, 13'h005, 2'b00, 1'b0, 16'h0);
    applyStimulus(CMD_WR,  2'd1, 13'h007, 2'b00, 1'b1, 16'hA55A);
    applyStimulus(CMD_RD,  2'd1, 13'h007, 2'b00, 1'b0, 16'h0);
    idle(1);
    checkOutput("cl3_z_before", 32'(dqIsZ), 32'd1);
    idle(1);
    checkOutput("cl3_beat", 32'(dq), 32'hA55A);
    idle(1);
    checkOutput("cl3_z_after", 32'(dqIsZ), 32'd1);
    checkOutput("cl3_no_err", 32'(errCount), 32'd0);

    $display("[TB] byte masks");
    applyStimulus(CMD_WR, 2'd1, 13'h008, 2'b00, 1'b1, 16'h1234);
    applyStimulus(CMD_WR, 2'd1, 13'h008, 2'b01, 1'b1, 16'hFFFF);
    applyStimulus(CMD_RD, 2'd1, 13'h008, 2'b00, 1'b0, 16'h0);
    idle(2);
    checkOutput("wr_mask_merge", 32'(dq), 32'hFF34);
    applyStimulus(CMD_RD, 2'd1, 13'h008, 2'b10, 1'b0, 16'h0);
    idle(2);
    checkOutput("rd_mask_hi_z", 32'(dqHiZLo34), 32'd1);
    idle(1);

    $display("[TB] auto-precharge then read idle bank");
    applyStimulus(CMD_RD, 2'd1, 13'h407, 2'b00, 1'b0, 16'h0);
    applyStimulus(CMD_RD, 2'd1, 13'h007, 2'b00, 1'b0, 16'h0);
    checkOutput("ap_err_pulse", 32'(err), 32'(ERR_ON));
    checkOutput("ap_err_count", 32'(errCount), ERR_ON ? 32'd1 : 32'd0);
    idle(1);
    checkOutput("ap_err_clear", 32'(err), 32'd0);
    checkOutput("ap_beat", 32'(dq), 32'hA55A);
    idle(1);
    checkOutput("idle_bank_beat", 32'(dq), 32'hA55A);
    idle(1);
    checkOutput("ap_z_after", 32'(dqIsZ), 32'd1);

    $display("[TB] CL2 back-to-back reads");
    applyStimulus(CMD_LMR, 2'd0, 13'h020, 2'b00, 1'b0, 16'h0);
    checkOutput("cl2_lmr_err", 32'(err), 32'd0);
    applyStimulus(CMD_ACT, 2'd2, 13'h003, 2'b00, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(CMD_WR, 2'd2, 13'(i), 2'b00, 1'b1, 16'h1000 + 16'(i));
    end
    for (int c = 0; c < 6; c++) begin
      if (c < 4) applyStimulus(CMD_RD, 2'd2, 13'(c), 2'b00, 1'b0, 16'h0);
      else idle(1);
      if (c == 0 || c == 5) checkOutput("b2b_z", 32'(dqIsZ), 32'd1);
      else checkOutput("b2b_beat", 32'(dq), 32'h1000 + 32'(c - 1));
    end

    $display("[TB] write during pending read");
    applyStimulus(CMD_RD, 2'd2, 13'h000, 2'b00, 1'b0, 16'h0);
    applyStimulus(CMD_WR, 2'd2, 13'h004, 2'b00, 1'b1, 16'h5555);
    checkOutput("drop_err", 32'(err), 32'(ERR_ON));
    checkOutput("drop_dq_z", 32'(dqIsZ), 32'd1);
    checkOutput("drop_err_count", 32'(errCount), ERR_ON ? 32'd2 : 32'd0);
    idle(1);
    checkOutput("drop_dq_z2", 32'(dqIsZ), 32'd1);
    applyStimulus(CMD_RD, 2'd2, 13'h004, 2'b00, 1'b0, 16'h0);
    idle(1);
    checkOutput("drop_write_done", 32'(dq), 32'h5555);
    idle(1);

    $display("[TB] illegal load mode");
    applyStimulus(CMD_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
    applyStimulus(CMD_LMR, 2'd0, 13'h031, 2'b00, 1'b0, 16'h0);
    checkOutput("bad_lmr_err", 32'(err), 32'(ERR_ON));
    checkOutput("bad_lmr_count", 32'(errCount), ERR_ON ? 32'd3 : 32'd0);
    applyStimulus(CMD_ACT, 2'd2, 13'h003, 2'b00, 1'b0, 16'h0);
    applyStimulus(CMD_RD,  2'd2, 13'h000, 2'b00, 1'b0, 16'h0);
    idle(1);
    checkOutput("bad_lmr_cl_kept", 32'(dq), 32'h1000);
    idle(1);

    $display("[TB] refresh counting");
    applyStimulus(CMD_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
    busIf.sdram_wire_cke = 1'b0;
    applyStimulus(CMD_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
    busIf.sdram_wire_cke = 1'b1;
    checkOutput("cke_low_ignored", 32'(refreshCount), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(CMD_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
    checkOutput("refresh_3", 32'(refreshCount), 32'd3);
    checkOutput("refresh_no_err", 32'(err), 32'd0);
    for (int i = 0; i < 65533; i++) applyStimulus(CMD_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
    checkOutput("refresh_wrap", 32'(refreshCount), 32'd0);
    applyStimulus(CMD_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
    checkOutput("refresh_after_wrap", 32'(refreshCount), 32'd1);

    $display("[TB] reset during CL3 read");
    applyStimulus(CMD_LMR, 2'd0, 13'h030, 2'b00, 1'b0, 16'h0);
    applyStimulus(CMD_ACT, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
    applyStimulus(CMD_WR,  2'd0, 13'h001, 2'b00, 1'b1, 16'hBEEF);
    applyStimulus(CMD_RD,  2'd0, 13'h001, 2'b00, 1'b0, 16'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_z", 32'(dqIsZ), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    checkOutput("rst_mid_no_beat", 32'(dqIsZ), 32'd1);
    idle(1);
    checkOutput("rst_mid_no_beat2", 32'(dqIsZ), 32'd1);
    checkOutput("rst_mid_mode", 32'(modeValid), 32'd0);
    checkOutput("rst_mid_refresh", 32'(refreshCount), 32'd0);
    checkOutput("rst_mid_err_count", 32'(errCount), 32'd0);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
